pipe_stage_skid_reg: RTL and testbench

- Parametrised pipeline stage register for the ARM core. Successor to the fixed-field decode/execute register.
- Carries an arbitrary-width control vector and data payload between pipeline stages.
- Provides a valid/ready handshake with a 2-entry skid buffer, so upstream never sees a combinational ready path. Supports synchronous flush (branch taken / hazard squash).
- Instantiated between IF/ID, ID/EXE, EXE/MEM and MEM/WB.

---
 rtl/pipe_stage_skid_reg.sv | 135 +++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// ============================================================================
// Module   : pipe_stage_skid_reg
// Purpose  : Parametrised valid/ready pipeline register with a 2-entry skid
//            buffer and synchronous flush. Optional stats counters are enabled
//            by defining PIPE_STAGE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid_reg #(
  parameter int CTRL_W     = 6,
  parameter int DATA_W     = 192,
  parameter int FLUSH_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_TWO   = 2'd2;

  logic [1:0]        r_state;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic w_accept;
  logic w_pop;

  // Ready and valid come straight from the state register: no comb path.
  assign in_ready  = (r_state != c_TWO);
  assign out_valid = (r_state != c_EMPTY);
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;
  assign occupancy = r_state;

  assign w_accept = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_state     <= c_EMPTY;
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
      if (FLUSH_DATA != 0) begin
        r_main_data <= '0;
        r_skid_data <= '0;
      end
    end else begin
      case (r_state)
        c_EMPTY: begin
          if (w_accept) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
            r_state     <= c_ONE;
          end
        end
        c_ONE: begin
          if (w_accept && w_pop) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end else if (w_accept) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
            r_state     <= c_TWO;
          end else if (w_pop) begin
            // Bubble carries no control side-effects downstream.
            r_main_ctrl <= '0;
            r_state     <= c_EMPTY;
          end
        end
        c_TWO: begin
          if (w_pop) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
            r_skid_ctrl <= '0;
            r_state     <= c_ONE;
          end
        end
        default: begin
          r_state     <= c_EMPTY;
          r_main_ctrl <= '0;
          r_skid_ctrl <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating counters; flush does not clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush && (r_state != c_EMPTY) && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
// Testbench for pipe_stage_skid_reg: queue-based reference model with a
// negedge monitor, directed scenarios followed by a randomized phase.
`default_nettype none

module tb_pipe_stage_skid_reg;

  localparam int CTRL_W     = 6;
  localparam int DATA_W     = 192;
  localparam int FLUSH_DATA = 1;
  localparam int ENT_W      = CTRL_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       flush_cnt;
`endif

  pipe_stage_skid_reg #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .FLUSH_DATA(FLUSH_DATA)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held entries, at most two.
  logic [ENT_W-1:0] exp_q[$];
  bit               idle_zero = 1'b1;   // payload known to be zero while empty
  longint           exp_stall = 0;
  longint           exp_flush = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      idle_zero = 1'b1;
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      int  sz;
      bit  do_pop, do_acc;
      sz = exp_q.size();
      if (sz > 0 && !out_ready) exp_stall++;
      if (flush && sz > 0) exp_flush++;
      if (flush) begin
        exp_q.delete();
        if (FLUSH_DATA != 0) idle_zero = 1'b1;
      end else begin
        do_pop = (sz > 0) && out_ready;
        do_acc = in_valid && (sz < 2);
        if (do_pop) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0 && !do_acc) idle_zero = 1'b0;
        end
        if (do_acc) exp_q.push_back({in_ctrl, in_data});
      end
    end
  end

  // Monitor: compare the presented head entry and status against the model.
  always @(negedge clk) begin
    logic [ENT_W-1:0]  head;
    logic [CTRL_W-1:0] e_ctrl;
    int                sz;
    sz     = exp_q.size();
    head   = (sz > 0) ? exp_q[0] : '0;
    e_ctrl = head[DATA_W +: CTRL_W];
    check("out_valid", 256'(out_valid), 256'(sz > 0));
    check("in_ready",  256'(in_ready),  256'(sz < 2));
    check("occupancy", 256'(occupancy), 256'(sz));
    check("out_ctrl",  256'(out_ctrl),  256'(e_ctrl));
    if (sz > 0)
      check("out_data", 256'(out_data), 256'(head[DATA_W-1:0]));
    else if (idle_zero)
      check("out_data_idle", 256'(out_data), 256'(0));
`ifdef PIPE_STAGE_STATS_EN
    check("stall_cnt", 256'(stall_cnt), 256'(exp_stall));
    check("flush_cnt", 256'(flush_cnt), 256'(exp_flush));
`endif
  end

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic cycle(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input bit ordy, input bit fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("reset_in_ready", 256'(in_ready), 256'(1));

    // Streaming at full throughput
    for (int i = 1; i <= 4; i++) cycle(1'b1, 6'(i + 8), DATA_W'(i), 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure fills the skid register, then drains in order
    cycle(1'b1, 6'h11, DATA_W'('h10), 1'b0, 1'b0);
    cycle(1'b1, 6'h22, DATA_W'('h20), 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    check("bp_data_hold", 256'(out_data), 256'('h10));
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("bp_ready_back", 256'(in_ready), 256'(1));
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with two held entries and a same-cycle input that must be dropped
    cycle(1'b1, 6'h01, DATA_W'('h40), 1'b0, 1'b0);
    cycle(1'b1, 6'h02, DATA_W'('h50), 1'b0, 1'b0);
    cycle(1'b1, 6'h3F, DATA_W'('h30), 1'b0, 1'b1);
    check("flush_data_zero", 256'(out_data), 256'(0));
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset between clock edges with one entry held
    cycle(1'b1, 6'h15, DATA_W'('h60), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 256'(out_valid), 256'(0));
    check("arst_out_ctrl",  256'(out_ctrl),  256'(0));
    check("arst_occupancy", 256'(occupancy), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    check("arst_in_ready", 256'(in_ready), 256'(1));

`ifdef PIPE_STAGE_STATS_EN
    cycle(1'b1, 6'h2A, DATA_W'('h70), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    check("stats_stall_5", 256'(stall_cnt), 256'(5));
    check("stats_flush_1", 256'(flush_cnt), 256'(1));
`endif

    // Bubble cycles after a single entry drains
    cycle(1'b1, 6'h3C, DATA_W'('h80), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 6'h3F, '1, 1'b1, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) < 70), 6'($urandom()), rand_data(),
            ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 3));
    end

    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
